// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects and
// the memory-wait FSM states.
package pipe_ctrl_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_e;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/fwd_unit.sv
// EX-stage operand forwarding comparator for a single operand. The MEM-stage
// result is younger than the WB result, so it wins when both match.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] rs_ex,
    input  logic [REG_W-1:0] rd_mem,
    input  logic             regwrite_mem,
    input  logic [REG_W-1:0] rd_wb,
    input  logic             regwrite_wb,
    output fwd_sel_e         sel
);

    // Pick the youngest in-flight producer of rs_ex; x0 is never forwarded.
    always_comb begin
        sel = FWD_RF;
        if (regwrite_mem && (rd_mem != '0) && (rd_mem == rs_ex)) begin
            sel = FWD_MEM;
        end else if (regwrite_wb && (rd_wb != '0) && (rd_wb == rs_ex)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller: memory-wait FSM with watchdog, prioritised
// stall/flush mux, per-operand forwarding and stall/flush counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rs1_id,
    input  logic [REG_W-1:0] rs2_id,
    input  logic             rs1_use_id,
    input  logic             rs2_use_id,
    input  logic [REG_W-1:0] rs1_ex,
    input  logic [REG_W-1:0] rs2_ex,
    input  logic [REG_W-1:0] rd_ex,
    input  logic             load_ex,
    input  logic             branch_taken_ex,
    input  logic [REG_W-1:0] rd_mem,
    input  logic             regwrite_mem,
    input  logic             dmem_req_mem,
    input  logic             dmem_ready,
    input  logic [REG_W-1:0] rd_wb,
    input  logic             regwrite_wb,
    output logic             pc_write_en,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             ex_mem_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    ctrl_state_e       state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              timeout_err_reg;
    logic [CNT_W-1:0]  stall_cnt_reg, flush_cnt_reg;

    logic miss, freeze, timeout_hit, load_use, branch_act;

    logic [REG_W-1:0] rs_ex_arr  [2];
    fwd_sel_e         fwd_sel_arr[2];

    assign rs_ex_arr[0] = rs1_ex;
    assign rs_ex_arr[1] = rs2_ex;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_unit u_fwd (
                .rs_ex        (rs_ex_arr[gi]),
                .rd_mem       (rd_mem),
                .regwrite_mem (regwrite_mem),
                .rd_wb        (rd_wb),
                .regwrite_wb  (regwrite_wb),
                .sel          (fwd_sel_arr[gi])
            );
        end
    endgenerate

    assign fwd_a = rst ? 2'd0 : fwd_sel_arr[0];
    assign fwd_b = rst ? 2'd0 : fwd_sel_arr[1];

    // Hazard conditions; a timeout cycle is always also a not-ready wait cycle.
    always_comb begin
        miss        = dmem_req_mem && !dmem_ready;
        freeze      = ((state_reg == RUN) && miss) ||
                      ((state_reg == MEM_WAIT) && !dmem_ready);
        timeout_hit = (state_reg == MEM_WAIT) && !dmem_ready &&
                      (wait_cnt_reg == WAIT_LAST);
        load_use    = load_ex && (rd_ex != '0) &&
                      ((rs1_use_id && (rs1_id == rd_ex)) ||
                       (rs2_use_id && (rs2_id == rd_ex)));
    end

    // Next-state logic for the memory-wait FSM and its watchdog counter.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            RUN: begin
                wait_cnt_next = '0;
                if (miss) begin
                    state_next = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                wait_cnt_next = wait_cnt_reg + 1'b1;
                if (dmem_ready || timeout_hit) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    // Priority mux: timeout (which cancels the access) over freeze, then
    // branch redirect, then load-use bubble.
    always_comb begin
        pc_write_en  = 1'b1;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        branch_act   = 1'b0;
        if (rst) begin
            pc_write_en = 1'b0;
        end else if (timeout_hit) begin
            pc_write_en  = 1'b0;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (freeze) begin
            pc_write_en  = 1'b0;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (branch_taken_ex) begin
            branch_act  = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_write_en = 1'b0;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    // State, watchdog, sticky error flag and performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= RUN;
            wait_cnt_reg    <= '0;
            timeout_err_reg <= 1'b0;
            stall_cnt_reg   <= '0;
            flush_cnt_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (timeout_hit) begin
                timeout_err_reg <= 1'b1;
            end
            if (!pc_write_en) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
            if (branch_act) begin
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_reg;
    assign stall_cnt   = stall_cnt_reg;
    assign flush_cnt   = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model that tracks outstanding-access freeze counts.
module tb_pipe_hazard_ctrl;

    localparam int TO    = 4;
    localparam int CNT_W = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
    logic       rs1_use_id, rs2_use_id, load_ex, branch_taken_ex;
    logic       regwrite_mem, dmem_req_mem, dmem_ready, regwrite_wb;
    logic       pc_write_en, if_id_stall, id_ex_stall, ex_mem_stall;
    logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic [1:0] fwd_a, fwd_b;
    logic       timeout_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: is an access outstanding, and how many freeze cycles it
    // has already consumed.
    bit          m_waiting;
    int          m_freezes;
    bit          m_terr;
    logic [31:0] m_stall, m_flush;

    pipe_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_use_id(rs1_use_id), .rs2_use_id(rs2_use_id),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
        .load_ex(load_ex), .branch_taken_ex(branch_taken_ex),
        .rd_mem(rd_mem), .regwrite_mem(regwrite_mem),
        .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
        .rd_wb(rd_wb), .regwrite_wb(regwrite_wb),
        .pc_write_en(pc_write_en),
        .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
        .ex_mem_stall(ex_mem_stall),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .timeout_err(timeout_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd_model(input logic [4:0] rs);
        if (regwrite_mem && rd_mem != 0 && rd_mem == rs) return 2'd2;
        if (regwrite_wb && rd_wb != 0 && rd_wb == rs) return 2'd1;
        return 2'd0;
    endfunction

    // Compare the DUT against the model for this cycle, then advance the
    // model as the coming clock edge will.
    task automatic model_step();
        bit f, t, lu, br;
        logic [7:0] ctrl_exp, ctrl_act;
        logic [3:0] fwd_exp;
        f  = m_waiting ? !dmem_ready : (dmem_req_mem && !dmem_ready);
        t  = m_waiting && !dmem_ready && (m_freezes == TO);
        lu = load_ex && rd_ex != 0 &&
             ((rs1_use_id && rs1_id == rd_ex) || (rs2_use_id && rs2_id == rd_ex));
        br = 1'b0;
        // order: pc, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush,
        //        id_ex_flush, ex_mem_flush, mem_wb_flush
        if (rst)                  ctrl_exp = 8'b0000_0000;
        else if (t)               ctrl_exp = 8'b0110_0011;
        else if (f)               ctrl_exp = 8'b0111_0001;
        else if (branch_taken_ex) begin ctrl_exp = 8'b1000_1100; br = 1'b1; end
        else if (lu)              ctrl_exp = 8'b0100_0100;
        else                      ctrl_exp = 8'b1000_0000;
        fwd_exp = rst ? 4'd0 : {fwd_model(rs1_ex), fwd_model(rs2_ex)};
        ctrl_act = {pc_write_en, if_id_stall, id_ex_stall, ex_mem_stall,
                    if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
        chk("ctrl", 32'(ctrl_act), 32'(ctrl_exp));
        chk("fwd", 32'({fwd_a, fwd_b}), 32'(fwd_exp));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
        if (rst) begin
            m_waiting = 0; m_freezes = 0; m_terr = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (t) begin
                m_terr = 1; m_waiting = 0; m_freezes = 0;
            end else if (f) begin
                m_waiting = 1; m_freezes++;
            end else begin
                m_waiting = 0; m_freezes = 0;
            end
            if (!ctrl_exp[7]) m_stall++;
            if (br) m_flush++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rst = 0;
        rs1_id = 0; rs2_id = 0; rs1_use_id = 0; rs2_use_id = 0;
        rs1_ex = 0; rs2_ex = 0; rd_ex = 0; load_ex = 0; branch_taken_ex = 0;
        rd_mem = 0; regwrite_mem = 0; dmem_req_mem = 0; dmem_ready = 0;
        rd_wb = 0; regwrite_wb = 0;
    endtask

    initial begin
        bit slow;
        m_waiting = 0; m_freezes = 0; m_terr = 0; m_stall = 0; m_flush = 0;
        clear_inputs();
        rst = 1;
        #1;
        chk("rst_pc", 32'(pc_write_en), 0);
        tick(); tick();
        chk("rst_stall_cnt", stall_cnt, 0);
        rst = 0;

        // Load-use: one bubble.
        load_ex = 1; rd_ex = 5; rs1_id = 5; rs1_use_id = 1;
        #1;
        chk("lu_pc", 32'(pc_write_en), 0);
        chk("lu_ifid_stall", 32'(if_id_stall), 1);
        chk("lu_idex_flush", 32'(id_ex_flush), 1);
        tick();
        chk("lu_stall_cnt", stall_cnt, 1);
        clear_inputs();
        #1;
        chk("lu_after_pc", 32'(pc_write_en), 1);
        tick();

        // Branch beats load-use.
        branch_taken_ex = 1; load_ex = 1; rd_ex = 5; rs1_id = 5; rs1_use_id = 1;
        #1;
        chk("br_ifid_flush", 32'(if_id_flush), 1);
        chk("br_idex_flush", 32'(id_ex_flush), 1);
        chk("br_no_stall", 32'(if_id_stall), 0);
        tick();
        chk("br_flush_cnt", flush_cnt, 1);
        chk("br_stall_cnt", stall_cnt, 1);
        clear_inputs();

        // Memory wait: exactly 3 freeze cycles.
        dmem_req_mem = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("mw_memwb_flush", 32'(mem_wb_flush), 1);
            chk("mw_pc", 32'(pc_write_en), 0);
            tick();
        end
        dmem_ready = 1;
        #1;
        chk("mw_done_flush", 32'(mem_wb_flush), 0);
        chk("mw_done_pc", 32'(pc_write_en), 1);
        tick();
        clear_inputs();
        #1;
        chk("mw_run_pc", 32'(pc_write_en), 1);
        chk("mw_stall_cnt", stall_cnt, 4);
        tick();

        // Timeout: 5th freeze cycle cancels the access.
        dmem_req_mem = 1;
        for (int k = 1; k <= 5; k++) begin
            #1;
            chk("to_exmem_flush", 32'(ex_mem_flush), (k == 5) ? 1 : 0);
            chk("to_exmem_stall", 32'(ex_mem_stall), (k == 5) ? 0 : 1);
            chk("to_err_before", 32'(timeout_err), 0);
            tick();
        end
        chk("to_err", 32'(timeout_err), 1);
        chk("to_stall_cnt", stall_cnt, 9);
        clear_inputs();
        #1;
        chk("to_run_pc", 32'(pc_write_en), 1);
        tick(); tick();
        chk("to_err_sticky", 32'(timeout_err), 1);

        // Forwarding.
        rd_mem = 7; rd_wb = 7; regwrite_mem = 1; regwrite_wb = 1; rs1_ex = 7; rs2_ex = 0;
        #1;
        chk("fwd_a_mem", 32'(fwd_a), 2);
        chk("fwd_b_rf", 32'(fwd_b), 0);
        tick();
        regwrite_mem = 0;
        #1;
        chk("fwd_a_wb", 32'(fwd_a), 1);
        tick();
        clear_inputs();

        // Reset in the 2nd MEM_WAIT cycle.
        dmem_req_mem = 1;
        tick(); tick();
        rst = 1;
        #1;
        chk("rmw_pc", 32'(pc_write_en), 0);
        chk("rmw_memwb", 32'(mem_wb_flush), 0);
        tick();
        chk("rmw_stall_cnt", stall_cnt, 0);
        chk("rmw_flush_cnt", flush_cnt, 0);
        chk("rmw_err", 32'(timeout_err), 0);
        clear_inputs();
        #1;
        chk("rmw_run_pc", 32'(pc_write_en), 1);
        tick();

        // Randomized traffic against the model.
        slow = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) slow = ($urandom_range(0, 1) == 1);
            rst             = ($urandom_range(0, 249) == 0);
            rs1_id          = 5'($urandom_range(0, 3));
            rs2_id          = 5'($urandom_range(0, 3));
            rs1_use_id      = 1'($urandom_range(0, 1));
            rs2_use_id      = 1'($urandom_range(0, 1));
            rs1_ex          = 5'($urandom_range(0, 3));
            rs2_ex          = 5'($urandom_range(0, 3));
            rd_ex           = 5'($urandom_range(0, 3));
            load_ex         = ($urandom_range(0, 2) == 0);
            branch_taken_ex = ($urandom_range(0, 7) == 0);
            rd_mem          = 5'($urandom_range(0, 3));
            regwrite_mem    = 1'($urandom_range(0, 1));
            rd_wb           = 5'($urandom_range(0, 3));
            regwrite_wb     = 1'($urandom_range(0, 1));
            dmem_req_mem    = ($urandom_range(0, 5) == 0);
            dmem_ready      = slow ? ($urandom_range(0, 11) == 0)
                                   : ($urandom_range(0, 1) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
